// File: rtl/scan_sig_checker.sv
// Scan-out integrity checker: folds the Shift-DR TDO stream into a CRC-32 MISR
// and issues a pass/fail verdict on Update-DR. Optional tamper lockout: SCAN_SIG_LOCKOUT_EN.
module scan_sig_checker #(
    parameter int              SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED = 32'hFFFFFFFF,
    parameter int              CNT_W = 16
) (
    input  logic             tck,
    input  logic             trst_n,
    input  logic             tdo_in,
    input  logic             capture_en,
    input  logic             shift_en,
    input  logic             update_en,
    input  logic [SIG_W-1:0] exp_sig,
    input  logic [CNT_W-1:0] exp_len,
    output logic [SIG_W-1:0] sig,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             lock
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // One MISR step: shift left, fold in the polynomial when the feedback bit is set.
    function automatic logic [SIG_W-1:0] crc_step(input logic [SIG_W-1:0] s, input logic b);
        logic fb;
        fb = s[SIG_W-1] ^ b;
        crc_step = {s[SIG_W-2:0], 1'b0} ^ (fb ? POLY : {SIG_W{1'b0}});
    endfunction

    logic [2:0]       state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [SIG_W-1:0] sig_abs_s;
    logic [CNT_W-1:0] cnt_abs_s;
    logic             sat_abs_s;
    logic             verdict_s;
    logic             locked_s;

    assign sig_abs_s = crc_step(sig_q, tdo_in);
    assign cnt_abs_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
    assign sat_abs_s = sat_q | (cnt_abs_s == CNT_MAX);
    assign verdict_s = (sig_q == exp_sig) && (cnt_q == exp_len) && !sat_q;

`ifdef SCAN_SIG_LOCKOUT_EN
    logic lock_q;

    // Lockout latches on a fail verdict and only trst_n clears it.
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            lock_q <= 1'b0;
        end else if (state_q == ST_CHECK && !verdict_s) begin
            lock_q <= 1'b1;
        end else begin
            lock_q <= lock_q;
        end
    end

    assign locked_s = lock_q;
`else
    assign locked_s = 1'b0;
`endif

    // Next-state logic; capture_en outranks update_en, which outranks shift_en.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        done_d  = 1'b0;
        if (capture_en && (state_q != ST_CHECK) && !locked_s) begin
            state_d = ST_ARMED;
            sig_d   = SEED;
            cnt_d   = {CNT_W{1'b0}};
            sat_d   = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ARMED, ST_SHIFT: begin
                    if (update_en) begin
                        state_d = ST_CHECK;
                    end else if (shift_en) begin
                        state_d = ST_SHIFT;
                        sig_d   = sig_abs_s;
                        cnt_d   = cnt_abs_s;
                        sat_d   = sat_abs_s;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_CHECK: begin
                    state_d = ST_DONE;
                    pass_d  = verdict_s;
                    fail_d  = !verdict_s;
                    done_d  = 1'b1;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_ARMED) || (state_d == ST_SHIFT) || (state_d == ST_CHECK);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= {CNT_W{1'b0}};
            sat_q   <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign sig     = sig_q;
    assign bit_cnt = cnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign fail    = fail_q;
    assign lock    = locked_s;

endmodule

// File: tb/tb_scan_sig_checker.sv
// Directed bench for scan_sig_checker; a narrow 4-bit counter makes saturation reachable.
module tb_scan_sig_checker;
    logic        tck = 1'b0;
    logic        trst_n = 1'b0;
    logic        tdo_in = 1'b0;
    logic        capture_en = 1'b0;
    logic        shift_en = 1'b0;
    logic        update_en = 1'b0;
    logic [31:0] exp_sig = 32'h0;
    logic [3:0]  exp_len = 4'h0;
    logic [31:0] sig;
    logic [3:0]  bit_cnt;
    logic        busy, done, pass, fail, lock;

    int checks = 0;
    int failures = 0;

    scan_sig_checker #(.CNT_W(4)) dut (
        .tck(tck), .trst_n(trst_n), .tdo_in(tdo_in),
        .capture_en(capture_en), .shift_en(shift_en), .update_en(update_en),
        .exp_sig(exp_sig), .exp_len(exp_len),
        .sig(sig), .bit_cnt(bit_cnt), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .lock(lock)
    );

    always #5 tck = ~tck;

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic capture();
        capture_en = 1'b1;
        step();
        capture_en = 1'b0;
    endtask

    task automatic shift_bit(input logic b);
        shift_en = 1'b1;
        tdo_in   = b;
        step();
        shift_en = 1'b0;
    endtask

    // Update-DR then one CHECK cycle; returns with the verdict visible.
    task automatic update(input logic [31:0] es, input logic [3:0] el);
        exp_sig   = es;
        exp_len   = el;
        update_en = 1'b1;
        step();
        update_en = 1'b0;
        chk("check_no_done_yet", {31'b0, done}, 32'd0);
        step();
        chk("verdict_done", {31'b0, done}, 32'd1);
    endtask

    task automatic do_reset();
        trst_n = 1'b0;
        step();
        trst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_pass", {31'b0, pass}, 32'd0);
        chk("rst_fail", {31'b0, fail}, 32'd0);
        chk("rst_lock", {31'b0, lock}, 32'd0);
        chk("rst_sig", sig, 32'hFFFFFFFF);
        chk("rst_cnt", {28'b0, bit_cnt}, 32'd0);

        // Shift/update in IDLE are ignored
        shift_bit(1'b0);
        update_en = 1'b1; step(); update_en = 1'b0;
        chk("idle_cnt", {28'b0, bit_cnt}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_done", {31'b0, done}, 32'd0);

        // Zero-length session
        capture();
        chk("zl_busy", {31'b0, busy}, 32'd1);
        chk("zl_sig", sig, 32'hFFFFFFFF);
        update(32'hFFFFFFFF, 4'd0);
        chk("zl_pass", {31'b0, pass}, 32'd1);
        chk("zl_fail", {31'b0, fail}, 32'd0);
        chk("zl_busy_done", {31'b0, busy}, 32'd0);
        step();
        chk("zl_done_drop", {31'b0, done}, 32'd0);
        chk("zl_pass_hold", {31'b0, pass}, 32'd1);

        // One bit '1', then back-to-back restart right after done
        capture();
        shift_bit(1'b1);
        chk("b1_sig", sig, 32'hFFFFFFFE);
        chk("b1_cnt", {28'b0, bit_cnt}, 32'd1);
        update(32'hFFFFFFFE, 4'd1);
        chk("b1_pass", {31'b0, pass}, 32'd1);
        capture();
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_pass_clr", {31'b0, pass}, 32'd0);
        chk("b2b_cnt", {28'b0, bit_cnt}, 32'd0);

        // Unpaused 5-bit reference 1,0,1,1,0
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
        chk("ref5_sig", sig, 32'hDD360FEF);
        chk("ref5_cnt", {28'b0, bit_cnt}, 32'd5);
        update(32'hDD360FEF, 4'd5);
        chk("ref5_pass", {31'b0, pass}, 32'd1);

        // DONE ignores shift and update
        shift_en = 1'b1; update_en = 1'b1; tdo_in = 1'b0;
        step(); step();
        shift_en = 1'b0; update_en = 1'b0;
        chk("done_hold_sig", sig, 32'hDD360FEF);
        chk("done_hold_cnt", {28'b0, bit_cnt}, 32'd5);
        chk("done_no_pulse", {31'b0, done}, 32'd0);
        chk("done_hold_pass", {31'b0, pass}, 32'd1);

        // capture + update in the same ARMED cycle: capture wins
        capture();
        shift_bit(1'b1);
        capture_en = 1'b1; update_en = 1'b1;
        step();
        capture_en = 1'b0; update_en = 1'b0;
        chk("cu_cnt", {28'b0, bit_cnt}, 32'd0);
        chk("cu_busy", {31'b0, busy}, 32'd1);
        step();
        chk("cu_no_done", {31'b0, done}, 32'd0);
        shift_bit(1'b1);
        chk("cu_armed_shift", {28'b0, bit_cnt}, 32'd1);

        // Reset mid-SHIFT after 10 bits
        capture();
        for (int i = 0; i < 10; i++) shift_bit(i[0]);
        chk("mid_cnt10", {28'b0, bit_cnt}, 32'd10);
        do_reset();
        chk("mid_busy", {31'b0, busy}, 32'd0);
        chk("mid_sig", sig, 32'hFFFFFFFF);
        chk("mid_cnt", {28'b0, bit_cnt}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_done", {31'b0, done}, 32'd0);
        end

        // Saturation boundary: 14 ones passes, 16 ones saturates at 15 and fails
        capture();
        for (int i = 0; i < 14; i++) shift_bit(1'b1);
        chk("sat14_sig", sig, 32'hFFFFC000);
        update(32'hFFFFC000, 4'd14);
        chk("sat14_pass", {31'b0, pass}, 32'd1);
        capture();
        for (int i = 0; i < 16; i++) shift_bit(1'b1);
        chk("sat16_cnt", {28'b0, bit_cnt}, 32'd15);
        chk("sat16_sig", sig, 32'hFFFF0000);
        update(32'hFFFF0000, 4'd15);
        chk("sat_fail", {31'b0, fail}, 32'd1);
        chk("sat_pass", {31'b0, pass}, 32'd0);
        do_reset();

        // Pause mid-shift: 1,0,1 / 5 idle cycles / 1,0; length mismatch
        capture();
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
        chk("pause3_sig", sig, 32'hF67DC496);
        for (int i = 0; i < 5; i++) begin
            tdo_in = i[0];
            step();
        end
        chk("pause_hold_sig", sig, 32'hF67DC496);
        chk("pause_hold_cnt", {28'b0, bit_cnt}, 32'd3);
        shift_bit(1'b1); shift_bit(1'b0);
        chk("pause_sig", sig, 32'hDD360FEF);
        chk("pause_cnt", {28'b0, bit_cnt}, 32'd5);
        update(32'hDD360FEF, 4'd4);
        chk("pause_fail", {31'b0, fail}, 32'd1);
        chk("pause_pass", {31'b0, pass}, 32'd0);
        do_reset();
        chk("lock_rst", {31'b0, lock}, 32'd0);

        // One bit '0' against the wrong signature
        capture();
        shift_bit(1'b0);
        chk("b0_sig", sig, 32'hFB3EE249);
        update(32'hFFFFFFFE, 4'd1);
        chk("b0_fail", {31'b0, fail}, 32'd1);
        chk("b0_pass", {31'b0, pass}, 32'd0);
`ifdef SCAN_SIG_LOCKOUT_EN
        chk("b0_lock", {31'b0, lock}, 32'd1);
        capture();
        chk("lk_busy", {31'b0, busy}, 32'd0);
        chk("lk_fail", {31'b0, fail}, 32'd1);
        chk("lk_lock", {31'b0, lock}, 32'd1);
`else
        chk("b0_lock", {31'b0, lock}, 32'd0);
        capture();
        chk("nl_busy", {31'b0, busy}, 32'd1);
        chk("nl_fail", {31'b0, fail}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scan_sig_checker.md
# scan_sig_checker

Scan-out integrity checker placed directly downstream of the decrypt–scan-chain–encrypt stage. It consumes the serial encrypted TDO stream during TAP Shift-DR and folds every shifted bit into a CRC-32 signature (MISR). On Update-DR it compares the signature and bit count against an expected value. It then reports pass or fail to the test controller, which detects tampered, truncated or padded scan sessions in the 3D stack.

## Interface
Parameters:
- SIG_W, 32, signature width
- POLY, 32'h04C11DB7, CRC feedback polynomial
- SEED, 32'hFFFFFFFF, signature value loaded at session start
- CNT_W, 16, shifted-bit counter width

Ports:
- tck  in  1  sole clock; all state changes on the rising edge
- trst_n  in  1  synchronous, active-low reset
- tdo_in  in  1  serial encrypted scan-out bit from the upstream stage
- capture_en  in  1  TAP Capture-DR strobe; starts a session
- shift_en  in  1  TAP Shift-DR qualifier; one bit per cycle
- update_en  in  1  TAP Update-DR strobe; ends the session
- exp_sig  in  SIG_W  expected signature, sampled in CHECK
- exp_len  in  CNT_W  expected shifted-bit count, sampled in CHECK
- sig  out  SIG_W  running signature
- bit_cnt  out  CNT_W  bits absorbed in the current session
- busy  out  1  high in ARMED, SHIFT or CHECK
- done  out  1  one-cycle pulse when the verdict is written
- pass  out  1  verdict: signature and length matched
- fail  out  1  verdict: mismatch or counter saturation
- lock  out  1  tamper lockout (see Configuration)

## Operation
- FSM states: IDLE, ARMED, SHIFT, CHECK, DONE.
- Strobe priority when several are high in one cycle: capture_en > update_en > shift_en.
- capture_en in any state except CHECK (and not while locked):
  - load sig=SEED, bit_cnt=0
  - clear pass, fail and the saturation flag
  - go to ARMED
- capture_en seen in CHECK is ignored; CHECK always completes first.
- ARMED:
  - shift_en absorbs tdo_in and moves to SHIFT
  - update_en moves to CHECK (zero-length session)
- SHIFT:
  - each cycle with shift_en absorbs one bit
  - shift_en low (Pause/Exit states) holds sig and bit_cnt
  - update_en moves to CHECK
- Absorb step:
  - fb = sig[SIG_W-1] ^ tdo_in
  - sig <= {sig[SIG_W-2:0],1'b0} ^ (fb ? POLY : 0)
  - bit_cnt increments and saturates at all-ones; reaching all-ones sets the sticky sat flag
- CHECK (exactly one cycle):
  - pass = (sig==exp_sig) && (bit_cnt==exp_len) && !sat
  - fail = !pass
  - done=1
  - go to DONE
- DONE: hold sig, bit_cnt, pass and fail. shift_en and update_en are ignored; only capture_en leaves DONE.
- In IDLE, shift_en and update_en are ignored.
- pass and fail are never high together. Both are 0 until the first verdict.

## Timing
- Reset values when trst_n is low at a rising edge:
  - state=IDLE, sig=SEED, bit_cnt=0
  - busy=0, done=0, pass=0, fail=0, lock=0
- Reset mid-session aborts with no verdict and no done pulse.
- capture_en sampled at edge N: ARMED and sig=SEED are visible after N.
- Bit latency: a bit with shift_en at edge N is reflected in sig and bit_cnt after N.
- Verdict latency: update_en at edge N gives CHECK after N. pass, fail and done are visible after N+1, and done drops after N+2.
- exp_sig and exp_len must be stable in the CHECK cycle only.
- Back-to-back sessions: capture_en in the cycle after done restarts with no dead cycle.

## Configuration
- Macro SCAN_SIG_LOCKOUT_EN.
- Defined:
  - a fail verdict sets lock=1, together with fail, and lock holds until trst_n
  - while locked, capture_en is ignored, the FSM stays in DONE and fail stays 1
- Undefined: lock is tied to 0 and fail clears on the next capture_en.

## Test plan
- Zero-length session: capture_en, then update_en with no shift; exp_sig=32'hFFFFFFFF, exp_len=0 -> pass=1 and done pulse two cycles after update_en.
- One bit: capture_en, shift tdo_in=1, then update_en -> sig=32'hFFFFFFFE, bit_cnt=1; exp_sig=32'hFFFFFFFE, exp_len=1 -> pass=1.
- One bit: capture_en, shift tdo_in=0 -> sig=32'hFB3EE249. exp_sig=32'hFFFFFFFE -> fail=1. With the macro defined, lock=1 and a following capture_en is ignored.
- Pause mid-shift:
  - shift 3 bits, hold shift_en=0 for 5 cycles, shift 2 bits
  - bit_cnt=5 and sig equals an unpaused 5-bit reference
  - exp_len=4 -> fail=1
- Reset mid-SHIFT: trst_n=0 for one cycle after 10 shifted bits -> state=IDLE, sig=32'hFFFFFFFF, bit_cnt=0, done never pulses.
- capture_en and update_en high in the same ARMED cycle -> capture wins: session restarts with bit_cnt=0, no verdict.
